// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    localparam int D_BIT_DEF = 8;

    localparam logic TX_START_ACT   = 1'b0;
    localparam logic TX_START_INACT = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LAUNCH    = 2'b01,
        WAIT_DONE = 2'b10
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock register-array FIFO with combinational head
module sync_fifo #(
    parameter int D_BIT  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [D_BIT-1:0]  wr_data,
    input  logic              rd_en,
    output logic [D_BIT-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [D_BIT-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_fire;
    logic              rd_fire;

    // Fire decisions use pre-edge full/empty, so a pop never makes room for a same-cycle write.
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte queue and launch controller ahead of the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int D_BIT  = D_BIT_DEF,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [D_BIT-1:0]  wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [D_BIT-1:0]  tx_data,
    input  logic              tx_done_tick,
    output logic              busy
);

    tx_state_t        state;
    tx_state_t        state_next;
    logic             tx_start_next;
    logic [D_BIT-1:0] tx_data_next;
    logic [D_BIT-1:0] head;
    logic             pop;

    sync_fifo #(
        .D_BIT  (D_BIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= TX_START_INACT;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            tx_start <= tx_start_next;
            tx_data  <= tx_data_next;
            overflow <= wr_en && full;
        end
    end

    // The transmitter has no busy flag, so state is the only record of its occupancy;
    // done ticks are honoured only once the launch cycle has passed.
    always_comb begin
        state_next    = state;
        tx_start_next = TX_START_INACT;
        tx_data_next  = tx_data;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    tx_data_next  = head;
                    tx_start_next = TX_START_ACT;
                    state_next    = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == LAUNCH) || (state == WAIT_DONE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a queue-based reference model
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       full, empty, overflow, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Reference: byte queue plus "transmitter owned" and "launch cycle" flags.
    logic [7:0] mq[$];
    bit         m_owned;
    bit         m_launch;
    logic [7:0] m_data;
    bit         m_ovf;

    logic [7:0] dut_launched[$];
    int         launch_cyc[$];
    logic [7:0] written[$];

    always #5 clk = ~clk;

    uart_tx_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_owned  = 1'b0;
        m_launch = 1'b0;
        m_data   = 8'h00;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input bit dn);
        int  sz;
        bit  take;
        sz    = mq.size();
        take  = !m_owned && (sz > 0);
        m_ovf = w && (sz == 16);
        if (take) begin
            m_data   = mq.pop_front();
            m_launch = 1'b1;
            m_owned  = 1'b1;
        end else if (m_launch) begin
            m_launch = 1'b0;
        end else if (m_owned && dn) begin
            m_owned = 1'b0;
        end
        if (w && sz < 16) mq.push_back(d);
    endtask

    task automatic check_all();
        chk("count",    32'(count),    32'(mq.size()));
        chk("full",     32'(full),     32'(mq.size() == 16));
        chk("empty",    32'(empty),    32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_start", 32'(tx_start), 32'(!m_launch));
        chk("tx_data",  32'(tx_data),  32'(m_data));
        chk("busy",     32'(busy),     32'(m_owned));
    endtask

    task automatic tick(input bit w, input logic [7:0] d, input bit dn);
        wr_en        = w;
        wr_data      = d;
        tx_done_tick = dn;
        @(posedge clk);
        cyc++;
        model_step(w, d, dn);
        #1;
        check_all();
        if (tx_start === 1'b0) begin
            dut_launched.push_back(tx_data);
            launch_cyc.push_back(cyc);
        end
        wr_en        = 1'b0;
        tx_done_tick = 1'b0;
    endtask

    task automatic clear_logs();
        dut_launched.delete();
        launch_cyc.delete();
        written.delete();
    endtask

    task automatic wait_launches(input int n);
        for (int i = 0; i < 200 && launch_cyc.size() < n; i++) tick(1'b0, 8'h00, 1'b0);
        chk("launch_seen", 32'(launch_cyc.size() >= n), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (busy === 1'b1 || empty === 1'b0); i++)
            tick(1'b0, 8'h00, busy === 1'b1 && tx_start === 1'b1);
        chk("drained", 32'(busy === 1'b0 && empty === 1'b1), 32'd1);
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_len"}, 32'(dut_launched.size()), 32'(written.size()));
        for (int i = 0; i < written.size() && i < dut_launched.size(); i++)
            chk(tag, 32'(dut_launched[i]), 32'(written[i]));
    endtask

    initial begin
        logic [7:0] v;
        int         done_at;
        int         we;

        model_reset();
        #2 rst = 1'b1;
        #1;
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset mid-LAUNCH with 3 bytes queued
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        tick(1'b1, 8'h04, 1'b0);
        tick(1'b1, 8'h05, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        chk("t1_in_launch", 32'(tx_start), 32'd0);
        chk("t1_queued", 32'(count), 32'd3);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t1_rst_count", 32'(count), 32'd0);
        chk("t1_rst_tx_start", 32'(tx_start), 32'd1);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_empty", 32'(empty), 32'd1);
        chk("t1_rst_tx_data", 32'(tx_data), 32'd0);
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // 2: single byte latency and one-cycle start pulse
        clear_logs();
        tick(1'b1, 8'hA5, 1'b0);
        we = cyc;
        chk("t2_not_empty", 32'(empty), 32'd0);
        wait_launches(1);
        if (launch_cyc.size() > 0) begin
            chk("t2_latency", 32'(launch_cyc[0] - we), 32'd1);
            chk("t2_data", 32'(dut_launched[0]), 32'hA5);
        end
        chk("t2_busy", 32'(busy), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("t2_pulse_one_clk", 32'(tx_start), 32'd1);
        drain();

        // 3: three bytes, done 40 clk after each launch, next launch one edge after done
        clear_logs();
        written = '{8'h11, 8'h22, 8'h33};
        foreach (written[i]) tick(1'b1, written[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_launches(k + 1);
            if (launch_cyc.size() > k) begin
                if (k > 0) chk("t3_gap", 32'(launch_cyc[k] - done_at), 32'd1);
                for (int i = 0; i < 60 && cyc < launch_cyc[k] + 39; i++) tick(1'b0, 8'h00, 1'b0);
                tick(1'b0, 8'h00, 1'b1);
                done_at = cyc;
            end
        end
        chk_order("t3_order");
        drain();

        // 4: fill to 16 while transmitter is busy, then overflow on a 17th write
        clear_logs();
        v = 8'($urandom_range(0, 254));
        written.push_back(v);
        tick(1'b1, v, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom_range(0, 254));
            written.push_back(v);
            tick(1'b1, v, 1'b0);
        end
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_count16", 32'(count), 32'd16);
        tick(1'b1, 8'hFF, 1'b0);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count_held", 32'(count), 32'd16);
        tick(1'b0, 8'h00, 1'b0);
        chk("t4_overflow_pulse", 32'(overflow), 32'd0);
        drain();
        chk_order("t4_order");
        foreach (dut_launched[i]) if (dut_launched[i] === 8'hFF) chk("t4_no_ff", 32'(dut_launched[i]), 32'd0);

        // 5: simultaneous write and pop at count 5, order across pointer wrap
        clear_logs();
        v = 8'($urandom);
        written.push_back(v);
        tick(1'b1, v, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            written.push_back(v);
            tick(1'b1, v, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b1);
        chk("t5_count5_idle", 32'(count), 32'd5);
        v = 8'($urandom);
        written.push_back(v);
        tick(1'b1, v, 1'b0);
        chk("t5_count_same", 32'(count), 32'd5);
        chk("t5_launched", 32'(tx_start), 32'd0);
        for (int i = 0; i < 13; i++) begin
            v = 8'($urandom);
            written.push_back(v);
            tick(1'b1, v, busy === 1'b1 && tx_start === 1'b1);
        end
        drain();
        chk_order("t5_order");

        // 6: spurious done ticks in IDLE and LAUNCH
        tick(1'b0, 8'h00, 1'b1);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("t6_launch", 32'(tx_start), 32'd0);
        tick(1'b0, 8'h00, 1'b1);
        chk("t6_busy_after_launch_tick", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
        chk("t6_still_busy", 32'(busy), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        chk("t6_released", 32'(busy), 32'd0);

        // 7: random traffic against the model
        for (int i = 0; i < 1500; i++)
            tick(($urandom % 3) == 0, 8'($urandom), ($urandom % 8) == 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
